robo_motion_sequencer: RTL and testbench

- Sequences the robot's two actuators, forward drive and turn.
- Arbitrates between two requesters: the wall-following navigation FSM (level requests avancar/girar) and a manual command port with a valid/ready handshake.
- Converts each granted request into a timed motor pulse, followed by a dead-time before the next move.
- Generates the decision tick that paces the navigation FSM, so the navigation FSM needs no private prescaler.

---
 rtl/robo_pkg.sv | 17 +
 rtl/robo_prescaler.sv | 31 +++
 rtl/robo_motion_sequencer.sv | 130 +++++++++++++
 tb/tb_robo_motion_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/robo_pkg.sv
// Shared types for the motion sequencer: FSM states and manual command encodings.
// Pure declarations; no latency or flow control of its own.
package robo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    TURN = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_FWD  = 2'b01;
  localparam logic [1:0] CMD_TURN = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

endpackage

// File: rtl/robo_prescaler.sv
// Decision-tick prescaler: tick on every TICK_DIV-th enabled cycle, combinational on enable.
// Counter is forced to 0 while disabled, so each enabled stretch restarts the count.
module robo_prescaler
  import robo_pkg::*;
#(
  parameter int TICK_DIV = 3,
  parameter int CNT_W    = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!enable || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/robo_motion_sequencer.sv
// Arbitrates navigation and manual requests into timed motor pulses plus dead-time; 1-cycle decide latency.
// Manual port stalls (man_ready=0) outside IDLE; navigation requests are level-sampled on nav_tick only.
module robo_motion_sequencer
  import robo_pkg::*;
#(
  parameter int STEP_CYCLES = 8,
  parameter int TURN_CYCLES = 12,
  parameter int DEAD_CYCLES = 2,
  parameter int TICK_DIV    = 3,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       nav_avancar,
  input  logic       nav_girar,
  input  logic       manual_mode,
  input  logic       man_valid,
  input  logic [1:0] man_cmd,
  output logic       man_ready,
  input  logic       stop,
  output logic       nav_tick,
  output logic       motor_fwd,
  output logic       motor_turn,
  output logic       busy,
  output logic       move_done
);

  localparam logic [CNT_W-1:0] STEP_LD = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             abort, abort_nxt;
  logic             tick_en;

  assign tick_en = (state == IDLE) && !manual_mode;

  robo_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (tick_en),
    .tick   (nav_tick)
  );

  // Outputs decode straight from state so an async reset drops the motors at once.
  assign motor_fwd  = (state == FWD);
  assign motor_turn = (state == TURN);
  assign busy       = (state != IDLE);
  assign man_ready  = (state == IDLE) && manual_mode && !stop;
  assign move_done  = (state == DEAD) && (timer == '0) && !abort;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      abort <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    abort_nxt = abort;
    case (state)
      IDLE: begin
        if (nav_tick) begin
          // Turning takes priority so the robot never drives into the wall it sees.
          if (nav_girar) begin
            state_nxt = TURN;
            timer_nxt = TURN_LD;
          end else if (nav_avancar) begin
            state_nxt = FWD;
            timer_nxt = STEP_LD;
          end
        end else if (man_valid && man_ready) begin
          case (man_cmd)
            CMD_FWD: begin
              state_nxt = FWD;
              timer_nxt = STEP_LD;
            end
            CMD_TURN: begin
              state_nxt = TURN;
              timer_nxt = TURN_LD;
            end
            CMD_NONE, CMD_STOP: begin
              state_nxt = IDLE;
            end
            default: begin
              state_nxt = IDLE;
            end
          endcase
        end
      end
      FWD, TURN: begin
        if (stop) begin
          state_nxt = DEAD;
          timer_nxt = DEAD_LD;
          abort_nxt = 1'b1;
        end else if (timer == '0) begin
          state_nxt = DEAD;
          timer_nxt = DEAD_LD;
        end else begin
          timer_nxt = timer - CNT_W'(1);
        end
      end
      DEAD: begin
        if (timer == '0) begin
          state_nxt = IDLE;
          abort_nxt = 1'b0;
        end else begin
          timer_nxt = timer - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
        abort_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_robo_motion_sequencer.sv
// Bench for robo_motion_sequencer: move-based reference model checked every cycle plus directed literal checks.
module tb_robo_motion_sequencer;

  localparam int STEP = 8;
  localparam int TRN  = 12;
  localparam int DT   = 2;
  localparam int TDIV = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       nav_avancar = 1'b0;
  logic       nav_girar = 1'b0;
  logic       manual_mode = 1'b0;
  logic       man_valid = 1'b0;
  logic [1:0] man_cmd = 2'b00;
  logic       man_ready;
  logic       stop = 1'b0;
  logic       nav_tick;
  logic       motor_fwd;
  logic       motor_turn;
  logic       busy;
  logic       move_done;

  int n_cmp = 0;
  int n_err = 0;

  robo_motion_sequencer #(
    .STEP_CYCLES (STEP),
    .TURN_CYCLES (TRN),
    .DEAD_CYCLES (DT),
    .TICK_DIV    (TDIV),
    .CNT_W       (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .nav_avancar (nav_avancar),
    .nav_girar   (nav_girar),
    .manual_mode (manual_mode),
    .man_valid   (man_valid),
    .man_cmd     (man_cmd),
    .man_ready   (man_ready),
    .stop        (stop),
    .nav_tick    (nav_tick),
    .motor_fwd   (motor_fwd),
    .motor_turn  (motor_turn),
    .busy        (busy),
    .move_done   (move_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a move is a motor phase of m_len cycles followed by DT dead cycles,
  // tracked by its age; idle time is counted to locate decision ticks.
  logic m_busy = 1'b0;
  int   m_kind = 0;
  int   m_age  = 0;
  int   m_len  = 0;
  logic m_abort = 1'b0;
  int   m_idle = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy  <= 1'b0;
      m_kind  <= 0;
      m_age   <= 0;
      m_len   <= 0;
      m_abort <= 1'b0;
      m_idle  <= 0;
    end else if (m_busy) begin
      if (m_age < m_len && stop) begin
        m_len   <= m_age + 1;
        m_abort <= 1'b1;
      end
      if (m_age == m_len + DT - 1) begin
        m_busy <= 1'b0;
        m_idle <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (!manual_mode && (m_idle % TDIV == TDIV - 1) && (nav_girar || nav_avancar)) begin
      m_busy  <= 1'b1;
      m_kind  <= nav_girar ? 2 : 1;
      m_len   <= nav_girar ? TRN : STEP;
      m_age   <= 0;
      m_abort <= 1'b0;
      m_idle  <= 0;
    end else if (manual_mode && man_valid && !stop && (man_cmd == 2'b01 || man_cmd == 2'b10)) begin
      m_busy  <= 1'b1;
      m_kind  <= int'(man_cmd);
      m_len   <= (man_cmd == 2'b10) ? TRN : STEP;
      m_age   <= 0;
      m_abort <= 1'b0;
      m_idle  <= 0;
    end else begin
      m_idle <= manual_mode ? 0 : m_idle + 1;
    end
  end

  // Single compare process, mid-cycle on the falling edge.
  always @(negedge clock) begin
    logic in_motor;
    in_motor = reset && m_busy && (m_age < m_len);
    check("motor_fwd", motor_fwd, in_motor && m_kind == 1);
    check("motor_turn", motor_turn, in_motor && m_kind == 2);
    check("busy", busy, reset && m_busy);
    check("move_done", move_done, reset && m_busy && (m_age == m_len + DT - 1) && !m_abort);
    check("nav_tick", nav_tick, reset && !m_busy && !manual_mode && (m_idle % TDIV == TDIV - 1));
    check("man_ready", man_ready, reset && !m_busy && manual_mode && !stop);
  end

  // Activity tallies and tick log used by the directed checks.
  int edges = 0;
  int fwd_tot = 0, turn_tot = 0, done_tot = 0, busy_tot = 0;
  int tick_q[$];

  always @(posedge clock or negedge reset) begin
    if (!reset) edges <= 0;
    else edges <= edges + 1;
  end

  always @(negedge clock) begin
    if (reset) begin
      if (motor_fwd) fwd_tot <= fwd_tot + 1;
      if (motor_turn) turn_tot <= turn_tot + 1;
      if (move_done) done_tot <= done_tot + 1;
      if (busy) busy_tot <= busy_tot + 1;
      if (nav_tick) tick_q.push_back(edges + 1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for a falling edge where the selected output is high.
  task automatic wait_neg(input string nm, input int which, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      case (which)
        0: seen = move_done;
        1: seen = motor_fwd;
        2: seen = motor_turn;
        default: seen = man_ready;
      endcase
    end
    if (!seen) check(nm, 0, 1);
  endtask

  int bf, bt, bd, bb, bq;

  task automatic take_base();
    bf = fwd_tot; bt = turn_tot; bd = done_tot; bb = busy_tot; bq = tick_q.size();
  endtask

  initial begin
    // 1: nav forward move from reset release
    #2 reset = 1'b0;
    nav_avancar = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    take_base();
    wait_neg("s1_done_timeout", 0, 40);
    @(posedge clock); #1;
    nav_avancar = 1'b0;
    step(6);
    check("s1_first_tick_edge", tick_q[bq], 3);
    check("s1_second_tick_edge", tick_q[bq + 1], 16);
    check("s1_fwd_cycles", fwd_tot - bf, STEP);
    check("s1_done_count", done_tot - bd, 1);

    // 2: both requests -> turn wins
    take_base();
    nav_avancar = 1'b1; nav_girar = 1'b1;
    step(3);
    nav_avancar = 1'b0; nav_girar = 1'b0;
    step(20);
    check("s2_turn_cycles", turn_tot - bt, TRN);
    check("s2_fwd_cycles", fwd_tot - bf, 0);
    check("s2_done_count", done_tot - bd, 1);

    // 3: manual command presented during an active nav move
    nav_avancar = 1'b1;
    step(3);
    nav_avancar = 1'b0;
    manual_mode = 1'b1; man_valid = 1'b1; man_cmd = 2'b01;
    @(negedge clock);
    check("s3_ready_while_busy", man_ready, 0);
    wait_neg("s3_ready_timeout", 3, 30);
    @(posedge clock); #1;
    man_valid = 1'b0;
    take_base();
    step(12);
    check("s3_fwd_cycles", fwd_tot - bf, STEP);
    check("s3_done_count", done_tot - bd, 1);
    man_valid = 1'b1; man_cmd = 2'b11;
    @(negedge clock);
    check("s3_stop_cmd_ready", man_ready, 1);
    @(posedge clock); #1;
    man_valid = 1'b0; man_cmd = 2'b00;
    take_base();
    step(8);
    check("s3_stopcmd_fwd", fwd_tot - bf, 0);
    check("s3_stopcmd_turn", turn_tot - bt, 0);
    check("s3_stopcmd_done", done_tot - bd, 0);
    check("s3_stopcmd_busy", busy_tot - bb, 0);

    // 4: emergency stop in the 5th turn cycle
    manual_mode = 1'b0;
    take_base();
    nav_girar = 1'b1;
    wait_neg("s4_turn_timeout", 2, 10);
    @(posedge clock); #1;
    nav_girar = 1'b0;
    step(3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(10);
    check("s4_turn_cycles", turn_tot - bt, 5);
    check("s4_done_count", done_tot - bd, 0);
    check("s4_busy_cycles", busy_tot - bb, 5 + DT);

    // 5: async reset mid-forward
    nav_avancar = 1'b1;
    wait_neg("s5_fwd_timeout", 1, 10);
    #2;
    nav_avancar = 1'b0;
    reset = 1'b0;
    #1;
    check("s5_fwd_in_reset", motor_fwd, 0);
    check("s5_busy_in_reset", busy, 0);
    step(2);
    reset = 1'b1;
    take_base();
    step(5);
    check("s5_first_tick_edge", tick_q[bq], 3);

    // 6: manual mode masks navigation entirely
    manual_mode = 1'b1;
    nav_avancar = 1'b1;
    take_base();
    step(20);
    check("s6_ticks", tick_q.size() - bq, 0);
    check("s6_fwd", fwd_tot - bf, 0);
    check("s6_turn", turn_tot - bt, 0);
    check("s6_busy", busy_tot - bb, 0);
    nav_avancar = 1'b0;
    manual_mode = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
